// File: rtl/display_scan_ctrl.sv
// Scans NUM_DIG hex digits through one shared 7-segment decoder, with a blanking gap between digits.
// Outputs are registered. New data waits in a shadow register and is applied at the next frame wrap.
`timescale 1ns/1ps
module display_scan_ctrl #(
    parameter int NUM_DIG   = 4,
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 carga,
    input  logic [4*NUM_DIG-1:0] dado,
    input  logic [NUM_DIG-1:0]   habilita,
    output logic                 pronto,
    output logic [3:0]           nibble,
    output logic                 modo,
    output logic [NUM_DIG-1:0]   anodo,
    output logic                 quadro
);

    typedef enum logic {GUARD = 1'b0, SCAN = 1'b1} state_e;

    localparam int CNT_MAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(NUM_DIG);

    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIG - 1);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 wrap;

    logic [4*NUM_DIG-1:0] act_dado_q, act_dado_d;
    logic [NUM_DIG-1:0]   act_hab_q, act_hab_d;
    logic [4*NUM_DIG-1:0] sh_dado_q, sh_dado_d;
    logic [NUM_DIG-1:0]   sh_hab_q, sh_hab_d;
    logic                 pend_q, pend_d;

    logic [NUM_DIG-1:0]   anodo_q, anodo_d;
    logic [3:0]           nibble_q, nibble_d;
    logic                 modo_q, modo_d;
    logic                 quadro_q, quadro_d;
    logic                 pronto_q, pronto_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= GUARD;
            cnt_q      <= '0;
            idx_q      <= '0;
            act_dado_q <= '0;
            act_hab_q  <= '0;
            sh_dado_q  <= '0;
            sh_hab_q   <= '0;
            pend_q     <= 1'b0;
            anodo_q    <= '1;
            nibble_q   <= '0;
            modo_q     <= 1'b0;
            quadro_q   <= 1'b0;
            pronto_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            act_dado_q <= act_dado_d;
            act_hab_q  <= act_hab_d;
            sh_dado_q  <= sh_dado_d;
            sh_hab_q   <= sh_hab_d;
            pend_q     <= pend_d;
            anodo_q    <= anodo_d;
            nibble_q   <= nibble_d;
            modo_q     <= modo_d;
            quadro_q   <= quadro_d;
            pronto_q   <= pronto_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        wrap    = 1'b0;
        case (state_q)
            GUARD: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end
            end
            SCAN: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = GUARD;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        wrap  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = GUARD;
                cnt_d   = '0;
            end
        endcase
    end

    // Apply and capture never coincide: a capture needs pronto=1, which means nothing is pending.
    always_comb begin
        act_dado_d = act_dado_q;
        act_hab_d  = act_hab_q;
        sh_dado_d  = sh_dado_q;
        sh_hab_d   = sh_hab_q;
        pend_d     = pend_q;
        if (wrap && pend_q) begin
            act_dado_d = sh_dado_q;
            act_hab_d  = sh_hab_q;
            pend_d     = 1'b0;
        end
        if (carga && pronto_q) begin
            sh_dado_d = dado;
            sh_hab_d  = habilita;
            pend_d    = 1'b1;
        end
    end

    // Decode from next-state values so the decoder inputs lead the anode by the whole guard slot.
    always_comb begin
        anodo_d  = '1;
        nibble_d = '0;
        modo_d   = 1'b0;
        for (int k = 0; k < NUM_DIG; k++) begin
            if (idx_d == IW'(k)) begin
                nibble_d = act_dado_d[4*k +: 4];
                modo_d   = act_hab_d[k];
                if (state_d == SCAN) begin
                    anodo_d[k] = 1'b0;
                end
            end
        end
        quadro_d = wrap;
        pronto_d = !pend_d;
    end

    assign pronto = pronto_q;
    assign nibble = nibble_q;
    assign modo   = modo_q;
    assign anodo  = anodo_q;
    assign quadro = quadro_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed scenarios plus random loads, checked each cycle against a frame-position model.
`timescale 1ns/1ps
module tb_display_scan_ctrl;

    localparam int ND = 4;
    localparam int DV = 3;
    localparam int BK = 1;
    localparam int SL = DV + BK;
    localparam int P  = ND * SL;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          carga = 1'b0;
    logic [15:0]   dado = '0;
    logic [3:0]    habilita = '0;
    logic          pronto;
    logic [3:0]    nibble;
    logic          modo;
    logic [3:0]    anodo;
    logic          quadro;

    int tests = 0;
    int fails = 0;
    int t = 0;

    // Model state: what the display shows and what is waiting to be shown.
    logic [15:0] m_dado = '0;
    logic [3:0]  m_hab  = '0;
    logic [15:0] s_dado = '0;
    logic [3:0]  s_hab  = '0;
    bit          m_pend = 1'b0;

    display_scan_ctrl #(.NUM_DIG(ND), .DIV(DV), .BLANK_CYC(BK)) dut (
        .clock    (clock),
        .reset    (reset),
        .carga    (carga),
        .dado     (dado),
        .habilita (habilita),
        .pronto   (pronto),
        .nibble   (nibble),
        .modo     (modo),
        .anodo    (anodo),
        .quadro   (quadro)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, expv);
        end
    endtask

    // Called at a negedge: check cycle t, drive this cycle's inputs, advance one clock.
    task automatic cyc(input logic c, input logic [15:0] d, input logic [3:0] h);
        int   p, slot, off;
        logic [3:0] ea;
        bit   apply, cap;
        p    = t % P;
        slot = p / SL;
        off  = p % SL;
        ea   = (off < BK) ? 4'hF : (4'hF & ~(4'b0001 << slot));
        chk("anodo",  16'(anodo),  16'(ea));
        chk("nibble", 16'(nibble), 16'(m_dado[4*slot +: 4]));
        chk("modo",   16'(modo),   16'(m_hab[slot]));
        chk("quadro", 16'(quadro), 16'(t > 0 && p == 0));
        chk("pronto", 16'(pronto), 16'(!m_pend));
        carga    = c;
        dado     = d;
        habilita = h;
        apply = (p == P - 1) && m_pend;
        cap   = c && !m_pend;
        if (apply) begin
            m_dado = s_dado;
            m_hab  = s_hab;
            m_pend = 1'b0;
        end
        if (cap) begin
            s_dado = d;
            s_hab  = h;
            m_pend = 1'b1;
        end
        @(posedge clock);
        t++;
        @(negedge clock);
        carga = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        carga = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset  = 1'b0;
        t      = 0;
        m_dado = '0;
        m_hab  = '0;
        s_dado = '0;
        s_hab  = '0;
        m_pend = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 4'h0);
    endtask

    task automatic goto_pos(input int pos);
        for (int i = 0; i < P && (t % P) != pos; i++) cyc(1'b0, 16'h0, 4'h0);
    endtask

    initial begin
        // Reset scan sequence: a full frame plus the first quadro pulse.
        @(posedge clock);
        do_reset();
        idle(20);

        // Mid-frame load, then a rejected load while busy.
        goto_pos(6);
        cyc(1'b1, 16'hA3F1, 4'b1111);
        idle(2);
        cyc(1'b1, 16'h5555, 4'b1111);
        idle(2 * P);

        // Dash digits.
        cyc(1'b1, 16'h1234, 4'b0101);
        idle(2 * P + 4);

        // Load on the wrap cycle is deferred one frame.
        goto_pos(P - 1);
        cyc(1'b1, 16'hBEEF, 4'b1111);
        idle(2 * P + 4);

        // Reset during digit 2 scan with a load pending.
        goto_pos(0);
        cyc(1'b1, 16'h7777, 4'b1010);
        goto_pos(2 * SL + BK + 1);
        do_reset();
        idle(2 * P + 2);

        // Random loads.
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
